freq_gen_bcd: RTL and testbench



---
 rtl/freq_gen_pkg.sv | 22 ++
 rtl/freq_gen_bcd_tw_divider.sv | 55 +++++
 rtl/freq_gen_bcd.sv | 133 +++++++++++++
 tb/tb_freq_gen_bcd.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_gen_pkg.sv
// Shared types and constants for the BCD-programmable NCO frequency generator.
package freq_gen_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CONV,
    CHECK,
    DIV,
    APPLY
  } state_t;

  localparam int BCD_DIGITS    = 8;
  localparam int BIN_W         = 27;
  localparam int BCD_MAX_DIGIT = 9;

  // One MSD-first BCD accumulation step: acc*10 + digit, using shifts instead of a multiplier.
  function automatic logic [BIN_W-1:0] bcd_step(input logic [BIN_W-1:0] acc,
                                                input logic [3:0]       digit);
    return (acc << 3) + (acc << 1) + BIN_W'(digit);
  endfunction

endpackage

// File: rtl/freq_gen_bcd_tw_divider.sv
// Serial restoring divider for the tuning word: q = floor(dividend * 2^Q_W / DIVISOR).
// One quotient bit per clock; done is high during the final iteration cycle.
module tw_divider #(
  parameter int DIVISOR = 50_000_000,
  parameter int REM_W   = 27,
  parameter int Q_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [REM_W-1:0] dividend,
  output logic             done,
  output logic [Q_W-1:0]   q
);

  localparam int                CNT_W = $clog2(Q_W);
  localparam logic [REM_W-1:0]  DIV_C = REM_W'(DIVISOR);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(Q_W - 1);

  logic [REM_W-1:0] rem;
  logic [REM_W-1:0] rem_sh;
  logic [CNT_W-1:0] cnt;
  logic             running;

  // rem stays below DIVISOR, so the doubled value always fits in REM_W bits.
  assign rem_sh = {rem[REM_W-2:0], 1'b0};
  assign done   = running && (cnt == LAST);

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values and the block order never matters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem     <= '0;
      q       <= '0;
      cnt     <= '0;
      running <= 1'b0;
    end else if (start) begin
      rem     <= dividend;
      q       <= '0;
      cnt     <= '0;
      running <= 1'b1;
    end else if (running) begin
      if (rem_sh >= DIV_C) begin
        rem <= rem_sh - DIV_C;
        q   <= {q[Q_W-2:0], 1'b1};
      end else begin
        rem <= rem_sh;
        q   <= {q[Q_W-2:0], 1'b0};
      end
      cnt <= cnt + 1'b1;
      if (cnt == LAST) running <= 1'b0;
    end
  end

endmodule

// File: rtl/freq_gen_bcd.sv
// BCD-programmable square-wave generator built on a phase accumulator.
// Define FREQ_GEN_PHASE_RESET_EN to restart the phase at 0 on every applied frequency.
module freq_gen_bcd
  import freq_gen_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int ACC_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [3:0]       d0,
  input  logic [3:0]       d1,
  input  logic [3:0]       d2,
  input  logic [3:0]       d3,
  input  logic [3:0]       d4,
  input  logic [3:0]       d5,
  input  logic [3:0]       d6,
  input  logic [3:0]       d7,
  output logic             fout,
  output logic [ACC_W-1:0] tword,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int          REM_W   = $clog2(CLK_HZ) + 1;
  localparam logic [31:0] NYQUIST = 32'(CLK_HZ / 2);

  state_t                       state;
  logic [BCD_DIGITS-1:0][3:0]   digits;
  logic [2:0]                   conv_idx;
  logic [3:0]                   cur_digit;
  logic [BIN_W-1:0]             bin;
  logic                         invalid;
  logic                         check_fail;
  logic                         div_start;
  logic                         div_done;
  logic [ACC_W-1:0]             div_q;
  logic [ACC_W-1:0]             acc;

  assign cur_digit  = digits[conv_idx];
  assign check_fail = invalid || (32'(bin) >= NYQUIST);
  assign div_start  = (state == CHECK) && !check_fail;
  assign fout       = acc[ACC_W-1];

  // NOTE: the digit capture register carries no reset; it is always written on
  // acceptance before CONV reads it, so reset would only add fan-out.
  always_ff @(posedge clk) begin
    if (state == IDLE && load) digits <= {d7, d6, d5, d4, d3, d2, d1, d0};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      conv_idx <= '0;
      bin      <= '0;
      invalid  <= 1'b0;
      tword    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            err      <= 1'b0;
            busy     <= 1'b1;
            bin      <= '0;
            invalid  <= 1'b0;
            conv_idx <= 3'(BCD_DIGITS - 1);
            state    <= CONV;
          end
        end
        CONV: begin
          bin <= bcd_step(bin, cur_digit);
          if (cur_digit > 4'(BCD_MAX_DIGIT)) invalid <= 1'b1;
          conv_idx <= conv_idx - 3'd1;
          if (conv_idx == 3'd0) state <= CHECK;
        end
        CHECK: begin
          if (check_fail) begin
            err   <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            state <= DIV;
          end
        end
        DIV: begin
          if (div_done) state <= APPLY;
        end
        APPLY: begin
          tword <= div_q;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The add in the APPLY cycle still uses the old word; the new one takes effect next edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
    end else begin
`ifdef FREQ_GEN_PHASE_RESET_EN
      if (state == APPLY) acc <= '0;
      else                acc <= acc + tword;
`else
      acc <= acc + tword;
`endif
    end
  end

  tw_divider #(
    .DIVISOR (CLK_HZ),
    .REM_W   (REM_W),
    .Q_W     (ACC_W)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (REM_W'(bin)),
    .done     (div_done),
    .q        (div_q)
  );

endmodule

// File: tb/tb_freq_gen_bcd.sv
// Directed self-checking bench for freq_gen_bcd with hand-computed tuning words.
// Honours FREQ_GEN_PHASE_RESET_EN when the design is built with it.
module tb_freq_gen_bcd;

  localparam int CLK_HZ = 50_000_000;
  localparam int ACC_W  = 32;

  localparam logic [ACC_W-1:0] TW_1M     = 32'd85899345;
  localparam logic [ACC_W-1:0] TW_2M     = 32'd171798691;
  localparam logic [ACC_W-1:0] TW_12M5   = 32'd1073741824;
  localparam logic [ACC_W-1:0] TW_MAX_OK = 32'd2147483562;

  logic             clk  = 1'b0;
  logic             rst  = 1'b0;
  logic             load = 1'b0;
  logic [3:0]       d0, d1, d2, d3, d4, d5, d6, d7;
  logic             fout, busy, done, err;
  logic [ACC_W-1:0] tword;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  freq_gen_bcd #(.CLK_HZ(CLK_HZ), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .load(load),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3), .d4(d4), .d5(d5), .d6(d6), .d7(d7),
    .fout(fout), .tword(tword), .busy(busy), .done(done), .err(err)
  );

  task automatic set_digits(input logic [31:0] v);
    d0 = v[3:0];   d1 = v[7:4];   d2 = v[11:8];  d3 = v[15:12];
    d4 = v[19:16]; d5 = v[23:20]; d6 = v[27:24]; d7 = v[31:28];
  endtask

  // Presents digits with load high so that the next rising edge is edge 0.
  task automatic start_load(input logic [31:0] v);
    @(negedge clk);
    set_digits(v);
    load = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  // Returns the edge number (after edge 0) at which done is seen, or -1 on timeout.
  task automatic wait_done(output int edges);
    edges = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        edges = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    set_digits(32'h0);
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({fout, busy, done, err, tword} !== '0) begin
      n_fail++;
      $display("FAIL reset_held: fout=%b busy=%b done=%b err=%b tword=%0d, all should be 0",
               fout, busy, done, err, tword);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({fout, busy, done, err, tword} !== '0) begin
      n_fail++;
      $display("FAIL reset_released: fout=%b busy=%b done=%b err=%b tword=%0d, all should be 0",
               fout, busy, done, err, tword);
    end
  endtask

  task automatic test_1mhz();
    int e, prev, last, gaps, bad;
    start_load(32'h01000000);
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL 1m_busy_after_edge0: busy=%b expected 1", busy);
    end
    wait_done(e);
    n_tests++;
    if (e !== 42) begin n_fail++; $display("FAIL 1m_done_edge: got %0d expected 42", e); end
    n_tests++;
    if ({err, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL 1m_flags: err=%b busy=%b expected 0 0", err, busy);
    end
    n_tests++;
    if (tword !== TW_1M) begin
      n_fail++;
      $display("FAIL 1m_tword: got %0d expected %0d", tword, TW_1M);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL 1m_done_pulse: done=%b expected 0", done); end
    prev = int'(fout);
    last = -1;
    gaps = 0;
    bad  = 0;
    for (int i = 0; i < 600; i++) begin
      @(posedge clk);
      #1;
      if (fout && prev == 0) begin
        if (last >= 0) begin
          gaps++;
          if (i - last < 49 || i - last > 51) bad++;
        end
        last = i;
      end
      prev = int'(fout);
    end
    n_tests++;
    if (bad !== 0 || gaps < 10) begin
      n_fail++;
      $display("FAIL 1m_fout_period: %0d of %0d gaps outside 49..51 clk, need 0 of at least 10",
               bad, gaps);
    end
  endtask

  task automatic test_quarter();
    int e, bad;
    logic s[16];
    start_load(32'h12500000);
    wait_done(e);
    n_tests++;
    if (e !== 42 || tword !== TW_12M5) begin
      n_fail++;
      $display("FAIL q_tword: edge=%0d tword=%0d expected edge 42 tword %0d", e, tword, TW_12M5);
    end
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1;
      s[i] = fout;
    end
    bad = 0;
    for (int i = 0; i < 14; i++) if (s[i] == s[i+2]) bad++;
    for (int i = 0; i < 12; i++) if (s[i] != s[i+4]) bad++;
    n_tests++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL q_fout_shape: %0d samples break the 2-high/2-low period-4 pattern", bad);
    end
  endtask

  task automatic test_bad_digit();
    int e, bad;
    logic s[$];
    logic err_at, busy_at;
    logic [ACC_W-1:0] tw_at;
    e = -1;
    err_at = 1'b0;
    busy_at = 1'b1;
    tw_at = '0;
    @(negedge clk);
    set_digits(32'h0000A000);
    load = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
    s.push_back(fout);
    for (int i = 1; i <= 24; i++) begin
      @(posedge clk);
      #1;
      s.push_back(fout);
      if (done && e < 0) begin
        e = i; err_at = err; busy_at = busy; tw_at = tword;
      end
    end
    n_tests++;
    if (e !== 9) begin n_fail++; $display("FAIL bad_done_edge: got %0d expected 9", e); end
    n_tests++;
    if ({err_at, busy_at} !== 2'b10) begin
      n_fail++;
      $display("FAIL bad_flags: err=%b busy=%b expected 1 0", err_at, busy_at);
    end
    n_tests++;
    if (tw_at !== TW_12M5) begin
      n_fail++;
      $display("FAIL bad_tword_kept: got %0d expected %0d", tw_at, TW_12M5);
    end
    bad = 0;
    for (int i = 0; i + 2 < s.size(); i++) if (s[i] == s[i+2]) bad++;
    n_tests++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL bad_fout_disturbed: %0d samples broke the running period-4 pattern", bad);
    end
    n_tests++;
    if (err !== 1'b1) begin n_fail++; $display("FAIL bad_err_held: err=%b expected 1", err); end
  endtask

  task automatic test_range();
    int e;
    start_load(32'h25000000);
    wait_done(e);
    n_tests++;
    if (e !== 9 || err !== 1'b1 || tword !== TW_12M5) begin
      n_fail++;
      $display("FAIL range_nyquist: edge=%0d err=%b tword=%0d expected 9 1 %0d",
               e, err, tword, TW_12M5);
    end
    start_load(32'h24999999);
    n_tests++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL range_err_cleared: err=%b expected 0", err); end
    wait_done(e);
    n_tests++;
    if (e !== 42 || err !== 1'b0 || tword !== TW_MAX_OK) begin
      n_fail++;
      $display("FAIL range_max_ok: edge=%0d err=%b tword=%0d expected 42 0 %0d",
               e, err, tword, TW_MAX_OK);
    end
  endtask

  task automatic test_ignore_busy();
    int e, extra;
    e = -1;
    start_load(32'h01000000);
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (i == 4) set_digits(32'h00000777);
      if (i == 5) set_digits(32'h02000000);
      load = (i == 5);
      @(posedge clk);
      #1;
      if (done) begin
        e = i;
        break;
      end
    end
    load = 1'b0;
    n_tests++;
    if (e !== 42 || err !== 1'b0 || tword !== TW_1M) begin
      n_fail++;
      $display("FAIL ignore_result: edge=%0d err=%b tword=%0d expected 42 0 %0d",
               e, err, tword, TW_1M);
    end
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (busy) extra++;
    end
    n_tests++;
    if (extra !== 0) begin
      n_fail++;
      $display("FAIL ignore_not_queued: busy high %0d cycles after done, expected 0", extra);
    end
  endtask

  task automatic test_back_to_back();
    int e;
    start_load(32'h12500000);
    wait_done(e);
    n_tests++;
    if (e !== 42 || tword !== TW_12M5) begin
      n_fail++;
      $display("FAIL b2b_first: edge=%0d tword=%0d expected 42 %0d", e, tword, TW_12M5);
    end
    set_digits(32'h02000000);
    load = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
    n_tests++;
    if ({busy, done} !== 2'b10) begin
      n_fail++;
      $display("FAIL b2b_accept: busy=%b done=%b expected 1 0", busy, done);
    end
    wait_done(e);
    n_tests++;
    if (e !== 42 || tword !== TW_2M) begin
      n_fail++;
      $display("FAIL b2b_second: edge=%0d tword=%0d expected 42 %0d", e, tword, TW_2M);
    end
  endtask

  task automatic test_zero();
    int e, changes;
    logic prev;
    start_load(32'h00000000);
    wait_done(e);
    n_tests++;
    if (e !== 42 || err !== 1'b0 || tword !== '0) begin
      n_fail++;
      $display("FAIL zero_tword: edge=%0d err=%b tword=%0d expected 42 0 0", e, err, tword);
    end
    @(posedge clk);
    #1;
    prev = fout;
    changes = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (fout != prev) changes++;
      prev = fout;
    end
    n_tests++;
    if (changes !== 0) begin
      n_fail++;
      $display("FAIL zero_fout_frozen: fout toggled %0d times, expected 0", changes);
    end
  endtask

  task automatic test_phase_reset();
    int e;
    start_load(32'h01000000);
    wait_done(e);
    repeat (37) @(posedge clk);
    start_load(32'h02000000);
    wait_done(e);
    n_tests++;
    if (e !== 42 || tword !== TW_2M) begin
      n_fail++;
      $display("FAIL switch_tword: edge=%0d tword=%0d expected 42 %0d", e, tword, TW_2M);
    end
`ifdef FREQ_GEN_PHASE_RESET_EN
    n_tests++;
    if (fout !== 1'b0) begin
      n_fail++;
      $display("FAIL switch_phase_zero: fout=%b after APPLY, expected 0", fout);
    end
`endif
  endtask

  task automatic test_reset_mid_div();
    int e;
    start_load(32'h01000000);
    repeat (15) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    n_tests++;
    if ({fout, busy, done, err, tword} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_div: fout=%b busy=%b done=%b err=%b tword=%0d, all should be 0",
               fout, busy, done, err, tword);
    end
    @(negedge clk);
    rst = 1'b1;
    start_load(32'h12500000);
    wait_done(e);
    n_tests++;
    if (e !== 42 || tword !== TW_12M5) begin
      n_fail++;
      $display("FAIL reset_recover: edge=%0d tword=%0d expected 42 %0d", e, tword, TW_12M5);
    end
  endtask

  initial begin
    test_reset();
    test_1mhz();
    test_quarter();
    test_bad_digit();
    test_range();
    test_ignore_busy();
    test_back_to_back();
    test_zero();
    test_phase_reset();
    test_reset_mid_div();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
